// File: rtl/vga_pkg.sv
// Shared VGA raster timing constants, colours and window helper used by the
// timing generator and by the renderers that consume its raster.
package vga_pkg;

    localparam int VGA_CLK_DIV         = 4;
    localparam int VGA_H_TOTAL         = 800;
    localparam int VGA_H_SYNC          = 96;
    localparam int VGA_H_VIS_START     = 144;
    localparam int VGA_H_VIS_END       = 784;
    localparam int VGA_V_TOTAL         = 525;
    localparam int VGA_V_SYNC          = 2;
    localparam int VGA_V_VIS_START     = 35;
    localparam int VGA_V_VIS_END       = 515;
    localparam int VGA_FRAMES_PER_TICK = 6;

    localparam logic [11:0] BLACK = 12'h000;
    localparam logic [11:0] RED   = 12'hF00;
    localparam logic [11:0] WHITE = 12'hFFF;

    // Height of one stacked row, in raster lines.
    localparam int ROW_HEIGHT = 10;

    // Half-open window test: lo <= val < hi.
    function automatic logic in_range(input logic [9:0] val,
                                      input logic [9:0] lo,
                                      input logic [9:0] hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Modulo-N event counter: pulses on the enabled cycle in which the count
// wraps from N-1 back to 0.
module tick_divider #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic pulse
);

    localparam int            W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0]  LAST = W'(N - 1);

    logic [W-1:0] count_r;
    logic         wrap_s;

    assign wrap_s = en && (count_r == LAST);

    // Count enabled events, returning to zero after N-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (wrap_s) begin
            count_r <= '0;
        end else if (en) begin
            count_r <= count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // Gated by rst so the strobe is quiet while held in reset, even for N=1.
    assign pulse = !rst && wrap_s;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel enable, hCount/vCount walk, zero-skew sync and
// bright, plus per-frame and slow game ticks for sprite motion.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV         = VGA_CLK_DIV,
    parameter int H_TOTAL         = VGA_H_TOTAL,
    parameter int H_SYNC          = VGA_H_SYNC,
    parameter int H_VIS_START     = VGA_H_VIS_START,
    parameter int H_VIS_END       = VGA_H_VIS_END,
    parameter int V_TOTAL         = VGA_V_TOTAL,
    parameter int V_SYNC          = VGA_V_SYNC,
    parameter int V_VIS_START     = VGA_V_VIS_START,
    parameter int V_VIS_END       = VGA_V_VIS_END,
    parameter int FRAMES_PER_TICK = VGA_FRAMES_PER_TICK
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       bright,
    output logic       hSync,
    output logic       vSync,
    output logic       pix_en,
    output logic       frame_tick,
    output logic       game_tick
);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SW   = 10'(H_SYNC);
    localparam logic [9:0] V_SW   = 10'(V_SYNC);
    localparam logic [9:0] H_VS   = 10'(H_VIS_START);
    localparam logic [9:0] H_VE   = 10'(H_VIS_END);
    localparam logic [9:0] V_VS   = 10'(V_VIS_START);
    localparam logic [9:0] V_VE   = 10'(V_VIS_END);

    logic [9:0] h_cnt_r;
    logic [9:0] v_cnt_r;
    logic [9:0] h_nxt_s;
    logic [9:0] v_nxt_s;
    logic       line_end_s;
    logic       frame_wrap_s;
    logic       game_wrap_s;
    logic       hsync_r;
    logic       vsync_r;
    logic       bright_r;
    logic       frame_tick_r;
    logic       game_tick_r;

    tick_divider #(.N(CLK_DIV)) u_pix_div (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .pulse (pix_en)
    );

    assign line_end_s   = pix_en && (h_cnt_r == H_LAST);
    assign frame_wrap_s = line_end_s && (v_cnt_r == V_LAST);

    tick_divider #(.N(FRAMES_PER_TICK)) u_game_div (
        .clk   (clk),
        .rst   (rst),
        .en    (frame_wrap_s),
        .pulse (game_wrap_s)
    );

    // Next raster position; only moves on pixel-enable cycles.
    always_comb begin
        h_nxt_s = h_cnt_r;
        v_nxt_s = v_cnt_r;
        if (frame_wrap_s) begin
            h_nxt_s = 10'd0;
            v_nxt_s = 10'd0;
        end else if (line_end_s) begin
            h_nxt_s = 10'd0;
            v_nxt_s = v_cnt_r + 10'd1;
        end else if (pix_en) begin
            h_nxt_s = h_cnt_r + 10'd1;
        end else begin
            h_nxt_s = h_cnt_r;
        end
    end

    // Counters plus sync/bright decoded from the next position, so every
    // registered output lines up with the count shown in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_r      <= 10'd0;
            v_cnt_r      <= 10'd0;
            hsync_r      <= 1'b0;
            vsync_r      <= 1'b0;
            bright_r     <= 1'b0;
            frame_tick_r <= 1'b0;
            game_tick_r  <= 1'b0;
        end else begin
            h_cnt_r      <= h_nxt_s;
            v_cnt_r      <= v_nxt_s;
            hsync_r      <= !(h_nxt_s < H_SW);
            vsync_r      <= !(v_nxt_s < V_SW);
            bright_r     <= in_range(h_nxt_s, H_VS, H_VE) && in_range(v_nxt_s, V_VS, V_VE);
            frame_tick_r <= frame_wrap_s;
            game_tick_r  <= game_wrap_s;
        end
    end

    assign hCount     = h_cnt_r;
    assign vCount     = v_cnt_r;
    assign hSync      = hsync_r;
    assign vSync      = vsync_r;
    assign bright     = bright_r;
    assign frame_tick = frame_tick_r;
    assign game_tick  = game_tick_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized-reset bench: three generator instances (default timing, a small
// raster, and the CLK_DIV=1/FRAMES_PER_TICK=1 corner) against an arithmetic model.
module tb_vga_timing_gen;

    localparam int NDUT   = 3;
    localparam int NCYC   = 40000;
    localparam int S_HT   = 20;
    localparam int S_HS   = 3;
    localparam int S_HVS  = 5;
    localparam int S_HVE  = 18;
    localparam int S_VT   = 12;
    localparam int S_VS   = 2;
    localparam int S_VVS  = 3;
    localparam int S_VVE  = 10;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       br;
        logic       pe;
        logic       ft;
        logic       gt;
    } vga_exp_t;

    int cfg_d   [NDUT] = '{4, 3, 1};
    int cfg_ht  [NDUT] = '{800, S_HT, S_HT};
    int cfg_hs  [NDUT] = '{96, S_HS, S_HS};
    int cfg_hvs [NDUT] = '{144, S_HVS, S_HVS};
    int cfg_hve [NDUT] = '{784, S_HVE, S_HVE};
    int cfg_vt  [NDUT] = '{525, S_VT, S_VT};
    int cfg_vs  [NDUT] = '{2, S_VS, S_VS};
    int cfg_vvs [NDUT] = '{35, S_VVS, S_VVS};
    int cfg_vve [NDUT] = '{515, S_VVE, S_VVE};
    int cfg_fpt [NDUT] = '{6, 3, 1};
    string nm   [NDUT] = '{"dflt", "small", "corner"};

    logic       clk;
    logic       rst [NDUT];
    logic [9:0] hc  [NDUT];
    logic [9:0] vc  [NDUT];
    logic       br  [NDUT];
    logic       hs  [NDUT];
    logic       vs  [NDUT];
    logic       pe  [NDUT];
    logic       ft  [NDUT];
    logic       gt  [NDUT];

    int vecs;
    int errs;
    int t     [NDUT];
    int rhold [NDUT];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vga_timing_gen u_dflt (
        .clk(clk), .rst(rst[0]), .hCount(hc[0]), .vCount(vc[0]), .bright(br[0]),
        .hSync(hs[0]), .vSync(vs[0]), .pix_en(pe[0]), .frame_tick(ft[0]), .game_tick(gt[0])
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_TOTAL(S_HT), .H_SYNC(S_HS), .H_VIS_START(S_HVS), .H_VIS_END(S_HVE),
        .V_TOTAL(S_VT), .V_SYNC(S_VS), .V_VIS_START(S_VVS), .V_VIS_END(S_VVE), .FRAMES_PER_TICK(3)
    ) u_small (
        .clk(clk), .rst(rst[1]), .hCount(hc[1]), .vCount(vc[1]), .bright(br[1]),
        .hSync(hs[1]), .vSync(vs[1]), .pix_en(pe[1]), .frame_tick(ft[1]), .game_tick(gt[1])
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_TOTAL(S_HT), .H_SYNC(S_HS), .H_VIS_START(S_HVS), .H_VIS_END(S_HVE),
        .V_TOTAL(S_VT), .V_SYNC(S_VS), .V_VIS_START(S_VVS), .V_VIS_END(S_VVE), .FRAMES_PER_TICK(1)
    ) u_corner (
        .clk(clk), .rst(rst[2]), .hCount(hc[2]), .vCount(vc[2]), .bright(br[2]),
        .hSync(hs[2]), .vSync(vs[2]), .pix_en(pe[2]), .frame_tick(ft[2]), .game_tick(gt[2])
    );

    // Expected outputs t clocks after reset release, from raster arithmetic:
    // pixel index p = t / CLK_DIV, position and frame number follow by div/mod.
    function automatic vga_exp_t model(input int i, input int tt);
        vga_exp_t e;
        int p;
        int h;
        int v;
        int fs;
        p  = tt / cfg_d[i];
        fs = cfg_ht[i] * cfg_vt[i];
        h  = p % cfg_ht[i];
        v  = (p / cfg_ht[i]) % cfg_vt[i];
        e.h  = 10'(h);
        e.v  = 10'(v);
        e.hs = !(h < cfg_hs[i]);
        e.vs = !(v < cfg_vs[i]);
        e.br = (h >= cfg_hvs[i]) && (h < cfg_hve[i]) && (v >= cfg_vvs[i]) && (v < cfg_vve[i]);
        e.pe = (tt % cfg_d[i]) == (cfg_d[i] - 1);
        e.ft = (p > 0) && (p % fs == 0) && (tt % cfg_d[i] == 0);
        e.gt = e.ft && ((p / fs) % cfg_fpt[i] == 0);
        return e;
    endfunction

    task automatic check_eq(input string tag, input int obs, input int exp_v);
        vecs++;
        if (obs != exp_v) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    initial begin
        vga_exp_t e;
        string    pfx;
        vecs = 0;
        errs = 0;
        for (int i = 0; i < NDUT; i++) begin
            rst[i]   = 1'b1;
            rhold[i] = 3;
            t[i]     = 0;
        end
        for (int cyc = 0; cyc < NCYC && errs < 50; cyc++) begin
            @(posedge clk);
            for (int i = 0; i < NDUT; i++) begin
                t[i] = rst[i] ? 0 : t[i] + 1;
            end
            @(negedge clk);
            for (int i = 0; i < NDUT; i++) begin
                e = model(i, t[i]);
                if (rst[i]) e.pe = 1'b0;
                pfx = $sformatf("%s@%0d", nm[i], cyc);
                check_eq({pfx, ".hCount"},     int'(hc[i]), int'(e.h));
                check_eq({pfx, ".vCount"},     int'(vc[i]), int'(e.v));
                check_eq({pfx, ".hSync"},      int'(hs[i]), int'(e.hs));
                check_eq({pfx, ".vSync"},      int'(vs[i]), int'(e.vs));
                check_eq({pfx, ".bright"},     int'(br[i]), int'(e.br));
                check_eq({pfx, ".pix_en"},     int'(pe[i]), int'(e.pe));
                check_eq({pfx, ".frame_tick"}, int'(ft[i]), int'(e.ft));
                check_eq({pfx, ".game_tick"},  int'(gt[i]), int'(e.gt));
                // Keep a long clean run first so many frames and game ticks occur.
                if (rhold[i] > 0) rhold[i]--;
                rst[i] = (rhold[i] > 0);
                if (!rst[i] && cyc > 9000 && $urandom_range(3999, 0) == 0) begin
                    rhold[i] = $urandom_range(4, 1);
                    rst[i]   = 1'b1;
                end
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Drives the raster interface that the game renderers (block_controller and later draw blocks) consume: hCount, vCount, bright, plus monitor sync.
- Divides the 100 MHz board clock to a 25 MHz pixel enable and walks an 800x525 raster.
- Also produces a once-per-frame tick and a slow game tick, which replace ad-hoc clock dividers for sprite motion.

Parameters:
- CLK_DIV, 4: board clocks per pixel; must be >= 1.
- H_TOTAL, 800: pixels per line.
- H_SYNC, 96: hSync low width, columns 0..95.
- H_VIS_START, 144: first visible column.
- H_VIS_END, 784: first column after the visible region.
- V_TOTAL, 525: lines per frame.
- V_SYNC, 2: vSync low width, lines 0..1.
- V_VIS_START, 35: first visible line.
- V_VIS_END, 515: first line after the visible region.
- FRAMES_PER_TICK, 6: frames per game_tick; must be >= 1.

Ports:
- clk  in  1  board clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- hCount  out  10  current column, 0..H_TOTAL-1.
- vCount  out  10  current line, 0..V_TOTAL-1.
- bright  out  1  high when the current pixel is visible.
- hSync  out  1  horizontal sync, active-low.
- vSync  out  1  vertical sync, active-low.
- pix_en  out  1  one-clk strobe; the counters advance on the edge that ends this cycle.
- frame_tick  out  1  one-clk pulse in the first clk cycle of a frame.
- game_tick  out  1  one-clk pulse on every FRAMES_PER_TICK-th frame_tick.

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high. All state is sampled on the rising edge of clk. rst overrides everything, including mid-frame and mid-divide.
- Reset values:
  - hCount=0, vCount=0, divider=0, frame counter=0.
  - hSync=0 and vSync=0 (column 0 and line 0 lie in the sync pulse), bright=0.
  - pix_en=0, frame_tick=0, game_tick=0.
- Pixel divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pix_en = (div==CLK_DIV-1), decoded combinationally from the div register.
  - With CLK_DIV=1, pix_en is constant 1 outside reset.
- Raster counters advance only on edges where pix_en=1:
  - hCount increments. At H_TOTAL-1 it wraps to 0 and vCount increments.
  - vCount at V_TOTAL-1 with hCount at H_TOTAL-1 wraps to 0.
  - No other transitions exist. Counts never reach H_TOTAL or V_TOTAL.
- Sync and bright are registered, computed from the next-count values, so they always match the hCount/vCount visible in the same cycle (zero skew):
  - hSync = !(hCount < H_SYNC)
  - vSync = !(vCount < V_SYNC)
  - bright = (H_VIS_START <= hCount < H_VIS_END) && (V_VIS_START <= vCount < V_VIS_END)
  - Visible window is columns 144..783 and lines 35..514. Line 514 is the bottom row that renderers draw to.
- frame_tick:
  - Registered. High for exactly one clk, in the cycle after the edge on which the counters wrap from (799,524) to (0,0).
  - Not asserted by the reset-to-(0,0) transition.
- game_tick:
  - A frame counter 0..FRAMES_PER_TICK-1 increments on each frame wrap and returns to 0 after FRAMES_PER_TICK-1.
  - game_tick is asserted in the same cycle as frame_tick when the counter returns to 0.
  - The first game_tick occurs at the FRAMES_PER_TICK-th wrap after reset.
- Timing at defaults:
  - Line = 3200 clk. Frame = 1,680,000 clk.
  - hSync low = 384 clk per line. vSync low = 6400 clk per frame.

Decomposition:
- Package vga_pkg holds:
  - the timing constants above;
  - 12-bit colour constants BLACK, RED, WHITE;
  - the row-height constant, 10 lines, shared with the stacking logic.
- One sub-module, tick_divider:
  - parameter N;
  - inputs clk, rst, en;
  - output pulse, asserted when the internal count wraps at N-1.
- It is instantiated twice:
  - pixel enable: en=1, N=CLK_DIV;
  - game tick: en=frame wrap, N=FRAMES_PER_TICK.

Test Plan:
- Reset release: hold rst 3 clks, then release -> hCount=0, vCount=0, hSync=0, vSync=0, bright=0. pix_en first high in clk cycle 4 after release. hCount=1 one clk after that.
- Horizontal timing: run one line -> hSync low for exactly 384 clk (hCount 0..95). bright rises when hCount=144 on line 35 and falls when hCount=784. Line period is 3200 clk.
- Frame wrap: run to (799,524) -> next advance gives (0,0). frame_tick is high exactly one clk. Frame period is 1,680,000 clk. vSync low only on lines 0..1.
- Game tick: run 12 frames -> game_tick is asserted on frame wraps 6 and 12 only, each coincident with frame_tick.
- Mid-operation reset: assert rst at (400,200) with div=2 -> next edge gives all outputs at reset values. No frame_tick or game_tick pulse. Counting restarts cleanly.
- Parameter corner: CLK_DIV=1, FRAMES_PER_TICK=1 -> pix_en is constant 1 out of reset. game_tick equals frame_tick every frame. Line period is 800 clk.
